// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Register map, INT_STAT bit positions and CTRL field layout
//                shared by the UART register file and its interrupt block.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int ADDR_CTRL     = 0;
    localparam int ADDR_BAUD_DIV = 1;
    localparam int ADDR_STATUS   = 2;
    localparam int ADDR_INT_EN   = 3;
    localparam int ADDR_INT_STAT = 4;
    localparam int ADDR_TX_DATA  = 5;
    localparam int ADDR_RX_DATA  = 6;
    localparam int ADDR_FIFO_LVL = 7;
    localparam int ADDR_FIRST_UNMAPPED = 8;

    localparam int INT_RX_AVAIL    = 0;
    localparam int INT_TX_EMPTY    = 1;
    localparam int INT_RX_OVERRUN  = 2;
    localparam int INT_FRAME_ERR   = 3;
    localparam int INT_PARITY_ERR  = 4;
    localparam int INT_TX_OVERFLOW = 5;
    localparam int INT_W           = 6;

    // Bits [1:0] are live FIFO levels and never latch.
    localparam logic [INT_W-1:0] STICKY_MASK = 6'b11_1100;

    typedef struct packed {
        logic two_stop;
        logic parity_odd;
        logic parity_en;
        logic rx_en;
        logic tx_en;
    } ctrl_reg_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_irq_ctrl
//  Description : INT_EN mask, sticky write-one-to-clear INT_STAT and the
//                registered interrupt line.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_irq_ctrl
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en_wen,
    input  logic             i_stat_wen,
    input  logic [INT_W-1:0] i_wdata,
    input  logic             i_rx_avail,
    input  logic             i_tx_empty,
    input  logic             i_evt_overrun,
    input  logic             i_evt_frame,
    input  logic             i_evt_parity,
    input  logic             i_evt_tx_overflow,
    output logic [INT_W-1:0] o_int_en,
    output logic [INT_W-1:0] o_int_stat,
    output logic             o_irq
);

    logic [INT_W-1:0] r_int_en;
    logic [INT_W-1:0] r_sticky;
    logic             r_irq;
    logic [INT_W-1:0] w_evt;
    logic [INT_W-1:0] w_clr;
    logic [INT_W-1:0] w_stat;

    always_comb begin
        w_evt                  = '0;
        w_evt[INT_RX_OVERRUN]  = i_evt_overrun;
        w_evt[INT_FRAME_ERR]   = i_evt_frame;
        w_evt[INT_PARITY_ERR]  = i_evt_parity;
        w_evt[INT_TX_OVERFLOW] = i_evt_tx_overflow;
    end

    assign w_clr = i_stat_wen ? i_wdata : '0;

    always_comb begin
        w_stat               = r_sticky;
        w_stat[INT_RX_AVAIL] = i_rx_avail;
        w_stat[INT_TX_EMPTY] = i_tx_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_en <= '0;
            r_sticky <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (i_en_wen) begin
                r_int_en <= i_wdata;
            end
            // OR-ing the event last lets a same-cycle event beat the clear.
            r_sticky <= ((r_sticky & ~w_clr) | w_evt) & STICKY_MASK;
            r_irq    <= |(w_stat & r_int_en);
        end
    end

    assign o_int_en   = r_int_en;
    assign o_int_stat = w_stat;
    assign o_irq      = r_irq;

endmodule : uart_irq_ctrl
`default_nettype wire

// File: rtl/uart_regs.sv
`default_nettype none
// ============================================================================
//  Module      : uart_regs
//  Description : UART control/status register file with TX/RX FIFO bridging
//                and a single registered interrupt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_regs
    import uart_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          REG_ADDR_WIDTH = 4,
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [15:0] BAUD_DIV_RESET = 16'd27,
    parameter int          LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic [DATA_WIDTH-1:0]     reg_wdata,
    input  logic                      reg_wen,
    input  logic                      reg_ren,
    output logic [DATA_WIDTH-1:0]     reg_rdata,
    output logic                      reg_error,
    output logic                      cfg_tx_en,
    output logic                      cfg_rx_en,
    output logic                      cfg_parity_en,
    output logic                      cfg_parity_odd,
    output logic                      cfg_two_stop,
    output logic [15:0]               cfg_baud_div,
    output logic                      tx_push,
    output logic [7:0]                tx_wdata,
    input  logic                      tx_full,
    input  logic                      tx_empty,
    input  logic [LVL_W-1:0]          tx_level,
    output logic                      rx_pop,
    input  logic [7:0]                rx_rdata,
    input  logic                      rx_empty,
    input  logic                      rx_full,
    input  logic [LVL_W-1:0]          rx_level,
    input  logic                      rx_overrun_evt,
    input  logic                      rx_frame_evt,
    input  logic                      rx_parity_evt,
    output logic                      irq
);

    ctrl_reg_t             r_ctrl;
    logic [15:0]           r_baud_div;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_rdata_next;
    logic [INT_W-1:0]      w_int_en;
    logic [INT_W-1:0]      w_int_stat;
    logic                  w_sel_ctrl, w_sel_baud, w_sel_status, w_sel_int_en;
    logic                  w_sel_int_stat, w_sel_tx, w_sel_rx, w_sel_lvl;
    logic                  w_wen, w_ren, w_tx_overflow;
    logic                  w_unused_ok;

    assign w_sel_ctrl     = (reg_addr == REG_ADDR_WIDTH'(ADDR_CTRL));
    assign w_sel_baud     = (reg_addr == REG_ADDR_WIDTH'(ADDR_BAUD_DIV));
    assign w_sel_status   = (reg_addr == REG_ADDR_WIDTH'(ADDR_STATUS));
    assign w_sel_int_en   = (reg_addr == REG_ADDR_WIDTH'(ADDR_INT_EN));
    assign w_sel_int_stat = (reg_addr == REG_ADDR_WIDTH'(ADDR_INT_STAT));
    assign w_sel_tx       = (reg_addr == REG_ADDR_WIDTH'(ADDR_TX_DATA));
    assign w_sel_rx       = (reg_addr == REG_ADDR_WIDTH'(ADDR_RX_DATA));
    assign w_sel_lvl      = (reg_addr == REG_ADDR_WIDTH'(ADDR_FIFO_LVL));

    assign reg_error = (reg_addr >= REG_ADDR_WIDTH'(ADDR_FIRST_UNMAPPED));

    // Gating with rst keeps an access that overlaps reset from reaching the FIFOs.
    assign w_wen         = reg_wen && !rst;
    assign w_ren         = reg_ren && !rst;
    assign tx_push       = w_wen && w_sel_tx && !tx_full;
    assign w_tx_overflow = w_wen && w_sel_tx && tx_full;
    assign tx_wdata      = reg_wdata[7:0];
    assign rx_pop        = w_ren && w_sel_rx && !rx_empty;

    always_comb begin
        w_rdata_next = '0;
        if (w_sel_ctrl) begin
            w_rdata_next[4:0] = r_ctrl;
        end else if (w_sel_baud) begin
            w_rdata_next[15:0] = r_baud_div;
        end else if (w_sel_status) begin
            w_rdata_next[3:0] = {rx_empty, rx_full, tx_empty, tx_full};
        end else if (w_sel_int_en) begin
            w_rdata_next[INT_W-1:0] = w_int_en;
        end else if (w_sel_int_stat) begin
            w_rdata_next[INT_W-1:0] = w_int_stat;
        end else if (w_sel_rx) begin
            if (!rx_empty) begin
                w_rdata_next[8:0] = {1'b1, rx_rdata};
            end
        end else if (w_sel_lvl) begin
            w_rdata_next[LVL_W-1:0]    = tx_level;
            w_rdata_next[16+:LVL_W]    = rx_level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_baud_div <= BAUD_DIV_RESET;
            r_rdata    <= '0;
        end else begin
            if (reg_wen && w_sel_ctrl) begin
                r_ctrl <= ctrl_reg_t'(reg_wdata[4:0]);
            end
            if (reg_wen && w_sel_baud) begin
                r_baud_div <= (reg_wdata[15:0] == 16'd0) ? 16'd1 : reg_wdata[15:0];
            end
            if (reg_ren) begin
                r_rdata <= w_rdata_next;
            end
        end
    end

    uart_irq_ctrl u_irq_ctrl (
        .clk               (clk),
        .rst               (rst),
        .i_en_wen          (w_wen && w_sel_int_en),
        .i_stat_wen        (w_wen && w_sel_int_stat),
        .i_wdata           (reg_wdata[INT_W-1:0]),
        .i_rx_avail        (!rx_empty),
        .i_tx_empty        (tx_empty),
        .i_evt_overrun     (rx_overrun_evt),
        .i_evt_frame       (rx_frame_evt),
        .i_evt_parity      (rx_parity_evt),
        .i_evt_tx_overflow (w_tx_overflow),
        .o_int_en          (w_int_en),
        .o_int_stat        (w_int_stat),
        .o_irq             (irq)
    );

    assign reg_rdata      = r_rdata;
    assign cfg_tx_en      = r_ctrl.tx_en;
    assign cfg_rx_en      = r_ctrl.rx_en;
    assign cfg_parity_en  = r_ctrl.parity_en;
    assign cfg_parity_odd = r_ctrl.parity_odd;
    assign cfg_two_stop   = r_ctrl.two_stop;
    assign cfg_baud_div   = r_baud_div;

    assign w_unused_ok = ^{reg_wdata[DATA_WIDTH-1:16]};

endmodule : uart_regs
`default_nettype wire

// File: tb/tb_uart_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_regs
//  Description : Self-checking bench for uart_regs; read data is scoreboarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_regs;

    localparam int LVL_W = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic        reg_wen = 1'b0;
    logic        reg_ren = 1'b0;
    logic [31:0] reg_rdata;
    logic        reg_error;
    logic        cfg_tx_en, cfg_rx_en, cfg_parity_en, cfg_parity_odd, cfg_two_stop;
    logic [15:0] cfg_baud_div;
    logic        tx_push;
    logic [7:0]  tx_wdata;
    logic        tx_full = 1'b0;
    logic        tx_empty = 1'b0;
    logic [LVL_W-1:0] tx_level = '0;
    logic        rx_pop;
    logic [7:0]  rx_rdata = '0;
    logic        rx_empty = 1'b1;
    logic        rx_full = 1'b0;
    logic [LVL_W-1:0] rx_level = '0;
    logic        rx_overrun_evt = 1'b0;
    logic        rx_frame_evt = 1'b0;
    logic        rx_parity_evt = 1'b0;
    logic        irq;

    int          n_checks = 0;
    int          n_errors = 0;
    int          push_cnt = 0;
    int          pop_cnt  = 0;
    logic        rd_pending = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    uart_regs dut (
        .clk            (clk),
        .rst            (rst),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_wen        (reg_wen),
        .reg_ren        (reg_ren),
        .reg_rdata      (reg_rdata),
        .reg_error      (reg_error),
        .cfg_tx_en      (cfg_tx_en),
        .cfg_rx_en      (cfg_rx_en),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_two_stop   (cfg_two_stop),
        .cfg_baud_div   (cfg_baud_div),
        .tx_push        (tx_push),
        .tx_wdata       (tx_wdata),
        .tx_full        (tx_full),
        .tx_empty       (tx_empty),
        .tx_level       (tx_level),
        .rx_pop         (rx_pop),
        .rx_rdata       (rx_rdata),
        .rx_empty       (rx_empty),
        .rx_full        (rx_full),
        .rx_level       (rx_level),
        .rx_overrun_evt (rx_overrun_evt),
        .rx_frame_evt   (rx_frame_evt),
        .rx_parity_evt  (rx_parity_evt),
        .irq            (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (tx_push) push_cnt++;
        if (rx_pop)  pop_cnt++;
        rd_pending <= reg_ren && !rst;
    end

    // Read data is valid the cycle after the strobe; compare against the queue.
    always @(negedge clk) begin
        if (rd_pending) begin
            if (exp_q.size() == 0) check("sb_underflow", reg_rdata, 32'hDEAD_BEEF);
            else                   check("rdata", reg_rdata, exp_q.pop_front());
        end
    end

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_addr = a; reg_wdata = d; reg_wen = 1'b1;
        @(negedge clk);
        reg_wen = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        reg_addr = a; reg_ren = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        reg_ren = 1'b0;
    endtask

    initial begin
        int p0;
        // Access overlapping reset must not reach the FIFOs.
        @(negedge clk);
        reg_addr = 4'd5; reg_wen = 1'b1; reg_wdata = 32'h77;
        #1 check("rst_push", {31'b0, tx_push}, 32'd0);
        reg_addr = 4'd6; reg_wen = 1'b0; reg_ren = 1'b1; rx_empty = 1'b0;
        #1 check("rst_pop", {31'b0, rx_pop}, 32'd0);
        @(negedge clk);
        reg_ren = 1'b0; rx_empty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdata", reg_rdata, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_baud", {16'b0, cfg_baud_div}, 32'd27);
        check("rst_cfg", {27'b0, cfg_two_stop, cfg_parity_odd, cfg_parity_en, cfg_rx_en, cfg_tx_en}, 32'd0);
        check("rst_pushes", push_cnt, 32'd0);

        do_read(4'd1, 32'h0000_001B);
        do_write(4'd1, 32'h0000_0000);
        do_read(4'd1, 32'h0000_0001);
        check("baud_clamp", {16'b0, cfg_baud_div}, 32'd1);

        do_write(4'd0, 32'h0000_0013);
        check("cfg_fields", {27'b0, cfg_two_stop, cfg_parity_odd, cfg_parity_en, cfg_rx_en, cfg_tx_en}, 32'h13);
        do_read(4'd0, 32'h0000_0013);

        // TX push, then push against a full FIFO.
        p0 = push_cnt;
        @(negedge clk);
        reg_addr = 4'd5; reg_wdata = 32'h41; reg_wen = 1'b1; tx_full = 1'b0;
        #1 check("tx_push", {31'b0, tx_push}, 32'd1);
        check("tx_wdata", {24'b0, tx_wdata}, 32'h41);
        @(negedge clk);
        reg_wen = 1'b0;
        check("push_once", push_cnt, p0 + 1);
        do_read(4'd4, 32'h0000_0000);
        tx_full = 1'b1;
        do_write(4'd5, 32'h41);
        check("push_full", push_cnt, p0 + 1);
        do_read(4'd4, 32'h0000_0020);
        do_read(4'd5, 32'h0000_0000);

        // Live status and levels.
        tx_empty = 1'b0; rx_full = 1'b1; rx_empty = 1'b0; tx_level = 5'd3; rx_level = 5'd16;
        do_read(4'd2, 32'h0000_0005);
        do_read(4'd7, 32'h0010_0003);
        tx_full = 1'b0; rx_full = 1'b0;

        // RX pop with data, then from empty FIFO.
        p0 = pop_cnt; rx_rdata = 8'h5A;
        @(negedge clk);
        reg_addr = 4'd6; reg_ren = 1'b1;
        exp_q.push_back(32'h0000_015A);
        #1 check("rx_pop", {31'b0, rx_pop}, 32'd1);
        @(negedge clk);
        reg_ren = 1'b0;
        check("pop_once", pop_cnt, p0 + 1);
        rx_empty = 1'b1;
        do_read(4'd6, 32'h0000_0000);
        check("pop_empty", pop_cnt, p0 + 1);

        // Sticky overrun and interrupt.
        do_write(4'd4, 32'h3F);
        do_read(4'd4, 32'h0000_0000);
        do_write(4'd3, 32'h04);
        do_read(4'd3, 32'h0000_0004);
        check("irq_idle", {31'b0, irq}, 32'd0);
        @(negedge clk);
        rx_overrun_evt = 1'b1;
        @(negedge clk);
        rx_overrun_evt = 1'b0;
        check("irq_lag", {31'b0, irq}, 32'd0);
        @(negedge clk);
        check("irq_set", {31'b0, irq}, 32'd1);
        @(negedge clk);
        reg_addr = 4'd4; reg_wdata = 32'h04; reg_wen = 1'b1; rx_overrun_evt = 1'b1;
        @(negedge clk);
        reg_wen = 1'b0; rx_overrun_evt = 1'b0;
        do_read(4'd4, 32'h0000_0004);
        check("irq_hold", {31'b0, irq}, 32'd1);
        do_write(4'd4, 32'h04);
        @(negedge clk);
        check("irq_clear", {31'b0, irq}, 32'd0);
        do_read(4'd4, 32'h0000_0000);

        // Unmapped slot.
        @(negedge clk);
        reg_addr = 4'd9;
        #1 check("reg_error", {31'b0, reg_error}, 32'd1);
        do_read(4'd9, 32'h0000_0000);
        check("err_hold", {31'b0, reg_error}, 32'd1);
        do_write(4'd9, 32'hFFFF_FFFF);
        do_read(4'd0, 32'h0000_0013);
        do_read(4'd1, 32'h0000_0001);
        do_read(4'd3, 32'h0000_0004);
        @(negedge clk);
        reg_addr = 4'd7;
        #1 check("no_error", {31'b0, reg_error}, 32'd0);

        repeat (3) @(negedge clk);
        check("sb_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_regs
`default_nettype wire
